serial_parallel_sub: RTL and testbench
======================================

Name: serial_parallel_sub

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational parallel subtractor.
- Computes in1 - in2 - borrow_in, or in1 + in2 + borrow_in in add mode, over WIDTH bits.
- Processes DIGIT bits per clock through one shared DIGIT-wide borrow/carry slice, trading latency for area.
- Sits between operand producers and result consumers using valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; DIGIT == WIDTH gives single-pass operation.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands; high only in IDLE.
mode  input  1  0 = subtract, 1 = add; captured with operands.
in1  input  WIDTH  minuend / augend.
in2  input  WIDTH  subtrahend / addend.
borrow_in  input  1  borrow-in (subtract) or carry-in (add).
out_valid  output  1  result valid; held until consumed.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  result, modulo 2^WIDTH.
borrow_out  output  1  true borrow (subtract) or carry-out (add).
overflow  output  1  two's-complement signed overflow.
zero  output  1  diff == 0.

Behaviour:
- Reset is synchronous and active-high; it is sampled only on clk rising edge.
- Reset values: state IDLE, out_valid 0, diff 0, borrow_out 0, overflow 0, zero 0. in_ready is high on the first cycle after rst deasserts.
- in_ready is asserted exactly when state is IDLE.
- N = WIDTH/DIGIT.
- FSM states and transitions:
  - IDLE: in_valid && in_ready at an edge captures in1, in2, mode and borrow_in, clears the result register, and moves to RUN with digit index 0.
  - RUN: each edge processes digit i, bits [i*DIGIT +: DIGIT].
    - The slice output is written into diff.
    - The slice borrow/carry is registered and feeds digit i+1.
    - When i == N-1: load borrow_out and overflow, compute zero, go to DONE.
  - DONE: out_valid = 1. out_valid && out_ready at an edge moves to IDLE and drops out_valid.
- No accept in the same cycle as result handoff, so throughput is one operation per N+2 cycles.
- Latency: acceptance at edge k gives out_valid high after edge k+N.
- Outputs are stable from the rising edge of out_valid until handoff. diff, borrow_out, overflow and zero keep their last values in IDLE.
- Subtract arithmetic: diff = (in1 - in2 - borrow_in) mod 2^WIDTH. borrow_out = 1 iff in1 < in2 + borrow_in, unsigned.
- Add arithmetic: diff = (in1 + in2 + borrow_in) mod 2^WIDTH. borrow_out = carry out of the MSB.
- overflow, subtract: in1 and in2 have different MSBs and diff MSB differs from in1 MSB.
- overflow, add: in1 and in2 have the same MSB and diff MSB differs from it.
- Inputs, including mode, are ignored outside the accepting edge. Changes during RUN have no effect.
- out_ready while not in DONE is ignored.
- rst at any time, including mid-RUN or in DONE with out_valid high:
  - the next state is IDLE with reset values;
  - the in-flight operation is discarded and never emitted.
- rst has priority over a simultaneous accept or handoff.
- DIGIT == WIDTH: RUN lasts one cycle, latency 1.

Test Plan:
1. WIDTH=16, DIGIT=4, mode=0, in1=0x1234, in2=0x0234, borrow_in=0 -> after 4 cycles out_valid=1, diff=0x1000, borrow_out=0, overflow=0, zero=0.
2. mode=0, in1=0x0000, in2=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1, overflow=0. Repeat with in1=in2=0x00A5, borrow_in=0 -> diff=0x0000, zero=1, borrow_out=0. Repeat with borrow_in=1 -> diff=0xFFFF, borrow_out=1.
3. Signed overflow:
   - mode=0, in1=0x8000, in2=0x0001 -> diff=0x7FFF, overflow=1, borrow_out=0.
   - mode=1, in1=0x7FFF, in2=0x0001 -> diff=0x8000, overflow=1, borrow_out=0.
   - mode=1, in1=0xFFFF, in2=0x0001 -> diff=0x0000, borrow_out=1, zero=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and all outputs stable, in_ready=0. Toggle in1 during the stall -> no change. Raise out_ready -> in_ready=1 next cycle.
5. Assert rst for one cycle at RUN digit 2 -> next cycle in_ready=1, out_valid=0, diff=0. A following operation returns a correct result and the aborted one is never emitted.
6. Parameter sweep (WIDTH,DIGIT) in {(4,4), (4,1), (32,8)} against a reference model, 1000 random operands each -> all results and flags match, latency exactly WIDTH/DIGIT.

Source files
------------

// File: rtl/serial_parallel_sub.sv
// Digit-serial WIDTH-bit subtract/add: one DIGIT-wide carry slice, WIDTH/DIGIT cycles from accept to out_valid.
// Accepts only in IDLE; the result and flags are held with out_valid high until out_ready.
`timescale 1ns/1ps
module serial_parallel_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             add;
  } opnd_t;

  state_t           state_q;
  opnd_t            op_q;
  logic             cy_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] sum_dig;
  logic             cy_d;
  logic [WIDTH-1:0] diff_d;
  logic             last;
  logic             a_msb;
  logic             b_msb;

  // Subtract runs as a + ~b + ~borrow, so cy_q holds an internal carry (not-borrow) in that mode.
  always_comb begin
    b_eff             = op_q.add ? op_q.b[DIGIT-1:0] : ~op_q.b[DIGIT-1:0];
    {cy_d, sum_dig}   = {1'b0, op_q.a[DIGIT-1:0]} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cy_q};
    diff_d            = (diff_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
    last              = (idx_q == IW'(N - 1));
    a_msb             = op_q.a[DIGIT-1];
    b_msb             = op_q.b[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cy_q     <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= '{a: in1, b: in2, add: mode};
            cy_q    <= mode ? borrow_in : ~borrow_in;
            idx_q   <= '0;
            diff_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Operands shift down so the current digit is always at bit 0; on the last digit that is the MSB digit.
          op_q.a <= op_q.a >> DIGIT;
          op_q.b <= op_q.b >> DIGIT;
          cy_q   <= cy_d;
          diff_q <= diff_d;
          idx_q  <= idx_q + IW'(1);
          if (last) begin
            borrow_q <= op_q.add ? cy_d : ~cy_d;
            ovf_q    <= op_q.add ? ((a_msb == b_msb) && (sum_dig[DIGIT-1] != a_msb))
                                 : ((a_msb != b_msb) && (sum_dig[DIGIT-1] != a_msb));
            zero_q   <= (diff_d == '0);
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;
endmodule

// File: tb/tb_serial_parallel_sub.sv
// Bench for serial_parallel_sub: directed 16/4 vectors and corner sequences, then random sweeps of other widths.
`timescale 1ns/1ps
module tb_serial_parallel_sub;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         borrow_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         zero;

  int n_checks = 0;
  int n_fail = 0;
  bit sweep_go = 1'b0;
  bit sweep_done [3];

  always #5 clk = ~clk;

  serial_parallel_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in1(in1), .in2(in2), .borrow_in(borrow_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
  );

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_before_accept", in_ready, 1);
    mode = m; in1 = a; in2 = b; borrow_in = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; mode = ~m; in1 = ~a; in2 = a; borrow_in = ~bi;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_out_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen;
    bit all_done;
    vecs[0]  = '{1'b0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h00A5, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h00A5, 16'h00A5, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'hABCD, 16'h0BCD, 1'b1, 16'h9FFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff, 0);
    check("reset_flags", {borrow_out, overflow, zero}, 0);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].bi);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), lat, N);
      check($sformatf("vec%0d_diff", i), diff, vecs[i].d);
      check($sformatf("vec%0d_borrow", i), borrow_out, vecs[i].bo);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ov);
      check($sformatf("vec%0d_zero", i), zero, vecs[i].z);
      handoff();
    end

    // Stall: inputs wiggle while the result is held.
    start_op(1'b0, 16'h1234, 16'h0234, 1'b0);
    wait_result(lat);
    check("stall_latency", lat, N);
    for (int c = 0; c < 10; c++) begin
      in1 = W'($urandom); in_valid = 1'b1; mode = ~mode;
      @(posedge clk); #1;
      check("stall_hold", {out_valid, in_ready, diff, borrow_out, overflow, zero},
            {1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0});
    end
    in_valid = 1'b0;
    handoff();

    out_ready = 1'b1;
    start_op(1'b1, 16'h0001, 16'h0002, 1'b0);
    wait_result(lat);
    check("eager_latency", lat, N);
    check("eager_diff", diff, 16'h0003);
    @(posedge clk); #1;
    check("eager_drop", {out_valid, in_ready}, 2'b01);
    out_ready = 1'b0;

    start_op(1'b0, 16'h5555, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst", {in_ready, out_valid, diff, borrow_out, overflow, zero}, {1'b1, 1'b0, 16'h0, 3'b000});
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrun_no_emit", seen, 0);
    start_op(1'b0, 16'h5555, 16'h1111, 1'b0);
    wait_result(lat);
    check("after_rst_latency", lat, N);
    check("after_rst_diff", diff, 16'h4444);
    handoff();

    start_op(1'b1, 16'h00FF, 16'h0001, 1'b0);
    wait_result(lat);
    check("done_rst_diff_before", diff, 16'h0100);
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    check("done_rst", {out_valid, in_ready, diff, borrow_out, overflow, zero}, {1'b0, 1'b1, 16'h0, 3'b000});

    in_valid = 1'b1; mode = 1'b0; in1 = 16'h0042; in2 = 16'h0001; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    check("rst_beats_accept", seen, 0);

    sweep_go = 1'b1;
    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(posedge clk);
      all_done = sweep_done[0] && sweep_done[1] && sweep_done[2];
    end
    check("sweep_complete", all_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 2) ? 32 : 4;
    localparam int SD = (g == 0) ? 4 : ((g == 1) ? 1 : 8);

    logic          s_in_valid, s_in_ready, s_mode, s_bin, s_out_valid, s_out_ready, s_bo, s_ov, s_z;
    logic [SW-1:0] s_in1, s_in2, s_diff;

    serial_parallel_sub #(.WIDTH(SW), .DIGIT(SD)) u_sweep (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode(s_mode),
      .in1(s_in1), .in2(s_in2), .borrow_in(s_bin), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .diff(s_diff), .borrow_out(s_bo), .overflow(s_ov), .zero(s_z)
    );

    initial begin
      logic [SW-1:0] a, b, ed;
      logic [SW:0]   full;
      logic          m, bi, ebo, eov;
      int            lat, t;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_mode = 1'b0; s_bin = 1'b0; s_in1 = '0; s_in2 = '0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int k = 0; k < 1000; k++) begin
        a = SW'($urandom); b = SW'($urandom); m = 1'($urandom); bi = 1'($urandom);
        if (m) full = {1'b0, a} + {1'b0, b} + (SW+1)'(bi);
        else   full = {1'b0, a} - {1'b0, b} - (SW+1)'(bi);
        ed  = full[SW-1:0];
        ebo = full[SW];
        eov = m ? ((a[SW-1] == b[SW-1]) && (ed[SW-1] != a[SW-1]))
                : ((a[SW-1] != b[SW-1]) && (ed[SW-1] != a[SW-1]));
        t = 0;
        while (!s_in_ready && t < 50) begin
          @(posedge clk); #1;
          t++;
        end
        s_in1 = a; s_in2 = b; s_mode = m; s_bin = bi; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_in1 = ~a; s_mode = ~m; s_bin = ~bi;
        lat = 0;
        while (!s_out_valid && lat < 100) begin
          @(posedge clk); #1;
          lat++;
        end
        check($sformatf("sweep%0d_latency", g), lat, SW / SD);
        check($sformatf("sweep%0d_result", g), {s_diff, s_bo, s_ov, s_z}, {ed, ebo, eov, ed == '0});
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
      end
      sweep_done[g] = 1'b1;
    end
  end
endmodule
